// File: rtl/ap_ctrl_hs_driver.sv
// Generic show-ahead FIFO used to hold per-call issue timestamps.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module ap_ctrl_hs_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          clr,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap explicitly so non-power-of-2 depths also work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Next-state for storage, pointers and occupancy; clr empties the FIFO.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_vld) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push_vld && !pop_vld) begin
                count_d = count_q + CW'(1);
            end else if (!push_vld && pop_vld) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// ap_ctrl_hs initiator: issues N calls to a child kernel, measures per-call latency and run time.
// Latency: first ap_start in the cycle after cfg_start; run_done one cycle after the final done.
// Backpressure: ap_start held until ap_ready; issue stalls while OUTS_DEPTH calls are outstanding.
module ap_ctrl_hs_driver #(
    parameter int CNT_W      = 32,
    parameter int CALL_W     = 16,
    parameter int OUTS_DEPTH = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cfg_start,
    input  logic [CALL_W-1:0] cfg_num_calls,
    output logic              busy,
    output logic              run_done,
    output logic              child_ap_start,
    input  logic              child_ap_ready,
    input  logic              child_ap_done,
    output logic [CALL_W-1:0] calls_issued,
    output logic [CALL_W-1:0] calls_completed,
    output logic [CNT_W-1:0]  last_latency,
    output logic [CNT_W-1:0]  max_latency,
    output logic [CNT_W-1:0]  total_cycles,
    output logic              err_protocol
);

    localparam int OCC_W = $clog2(OUTS_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CALL_W-1:0] num_q, num_d;
    logic [CALL_W-1:0] issued_q, issued_d;
    logic [CALL_W-1:0] completed_q, completed_d;
    logic [CNT_W-1:0]  last_lat_q, last_lat_d;
    logic [CNT_W-1:0]  max_lat_q, max_lat_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;

    logic              fifo_clr;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_head;
    logic [OCC_W-1:0]  fifo_count;
    logic              fifo_empty;

    logic              can_issue;
    logic              accept;
    logic              done_take;
    logic              bypass;
    logic [CNT_W-1:0]  lat;
    logic [CALL_W-1:0] issued_inc;
    logic [CALL_W-1:0] completed_inc;

    // Handshake decode. ap_start is a pure function of registered state so that
    // reset drops it immediately and a child may answer combinationally.
    always_comb begin
        fifo_empty     = (fifo_count == '0);
        can_issue      = (issued_q < num_q) && (fifo_count < OCC_W'(OUTS_DEPTH));
        child_ap_start = (state_q == ST_ISSUE) && (hold_q || can_issue);
        accept         = child_ap_start && child_ap_ready;
        // A done is only legal against an outstanding call or the one accepted now.
        done_take      = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) &&
                         child_ap_done && (!fifo_empty || accept);
        bypass         = done_take && fifo_empty;
        fifo_push      = accept && !bypass;
        fifo_pop       = done_take && !fifo_empty;
        fifo_clr       = (state_q == ST_IDLE) && cfg_start;
        lat            = bypass ? '0 : (cyc_q - fifo_head);
        issued_inc     = issued_q + CALL_W'(1);
        completed_inc  = completed_q + CALL_W'(1);
        hold_d         = child_ap_start && !child_ap_ready;
    end

    // Run FSM, statistics and protocol checking.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        last_lat_d  = last_lat_q;
        max_lat_d   = max_lat_q;
        total_d     = total_q;
        cyc_d       = cyc_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    num_d       = cfg_num_calls;
                    issued_d    = '0;
                    completed_d = '0;
                    last_lat_d  = '0;
                    max_lat_d   = '0;
                    total_d     = '0;
                    cyc_d       = '0;
                    err_d       = 1'b0;
                    state_d     = (cfg_num_calls == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE, ST_DRAIN: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (accept) begin
                    issued_d = issued_inc;
                end
                if (done_take) begin
                    completed_d = completed_inc;
                    last_lat_d  = lat;
                    if (lat > max_lat_q) begin
                        max_lat_d = lat;
                    end
                end
                // The final done can land in ISSUE only as a bypass of call N.
                if (done_take && (completed_inc == num_q)) begin
                    state_d = ST_DONE;
                    total_d = cyc_q + CNT_W'(1);
                end else if ((state_q == ST_ISSUE) && accept && (issued_inc == num_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Any done that cannot be matched to a call is a protocol error.
        if (child_ap_done && !done_take) begin
            err_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            last_lat_q  <= '0;
            max_lat_q   <= '0;
            total_q     <= '0;
            cyc_q       <= '0;
            err_q       <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            last_lat_q  <= last_lat_d;
            max_lat_q   <= max_lat_d;
            total_q     <= total_d;
            cyc_q       <= cyc_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
        end
    end

    ap_ctrl_hs_fifo #(
        .W     (CNT_W),
        .DEPTH (OUTS_DEPTH)
    ) u_ts_fifo (
        .core_clk (ap_clk),
        .arst_n   (ap_rst_n),
        .clr      (fifo_clr),
        .push_vld (fifo_push),
        .push_dat (cyc_q),
        .pop_vld  (fifo_pop),
        .pop_dat  (fifo_head),
        .count    (fifo_count)
    );

    assign busy            = (state_q != ST_IDLE);
    assign run_done        = (state_q == ST_DONE);
    assign calls_issued    = issued_q;
    assign calls_completed = completed_q;
    assign last_latency    = last_lat_q;
    assign max_latency     = max_lat_q;
    assign total_cycles    = total_q;
    assign err_protocol    = err_q;

endmodule
